// File: rtl/div64x32_if.sv
// Start/busy handshake and result bus shared by div64x32 and its controller.
// Optional div_zero flag present when DIV64X32_DIV0_FLAG_EN is defined.
interface div64x32_if;
  logic        start;
  logic [63:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        ovf;
`ifdef DIV64X32_DIV0_FLAG_EN
  logic        div_zero;
`endif

  modport master (
    output start, dividend, divisor,
`ifdef DIV64X32_DIV0_FLAG_EN
    input  div_zero,
`endif
    input  busy, quotient, remainder, ovf
  );

  modport slave (
    input  start, dividend, divisor,
`ifdef DIV64X32_DIV0_FLAG_EN
    output div_zero,
`endif
    output busy, quotient, remainder, ovf
  );
endinterface

// File: rtl/div64x32.sv
// Sequential radix-2 restoring divider, 64/32 -> 32 quotient + 32 remainder, one bit per clock.
// Define DIV64X32_DIV0_FLAG_EN to add the div_zero output flag.
module div64x32 (
  input  logic       clk,
  input  logic       reset,
  div64x32_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_OVF  = 2'd2;

  logic [1:0]  r_state;
  logic [32:0] r_rem;
  logic [31:0] r_low;
  logic [31:0] r_div;
  logic [4:0]  r_cnt;
  logic [31:0] r_quotient;
  logic [31:0] r_remainder;
  logic        r_ovf;
  logic        r_busy;
`ifdef DIV64X32_DIV0_FLAG_EN
  logic        r_div_zero;
`endif

  logic [32:0] w_trial;
  logic [32:0] w_diff;
  logic        w_qbit;
  logic [32:0] w_next_rem;

  // 33-bit trial: the shifted-out MSB of the partial remainder must take part in the compare.
  assign w_trial    = {r_rem[31:0], r_low[31]};
  assign w_diff     = w_trial - {1'b0, r_div};
  assign w_qbit     = (w_trial >= {1'b0, r_div});
  assign w_next_rem = w_qbit ? w_diff : w_trial;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_rem       <= '0;
      r_low       <= '0;
      r_div       <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_ovf       <= 1'b0;
      r_busy      <= 1'b0;
`ifdef DIV64X32_DIV0_FLAG_EN
      r_div_zero  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_div  <= bus.divisor;
            r_ovf  <= 1'b0;
            r_busy <= 1'b1;
`ifdef DIV64X32_DIV0_FLAG_EN
            r_div_zero <= 1'b0;
`endif
            // High word >= divisor means a 33+ bit quotient or a zero divisor.
            if (bus.dividend[63:32] >= bus.divisor) begin
              r_state <= S_OVF;
            end else begin
              r_state <= S_RUN;
              r_rem   <= {1'b0, bus.dividend[63:32]};
              r_low   <= bus.dividend[31:0];
              r_cnt   <= 5'd31;
            end
          end
        end

        S_RUN: begin
          r_rem      <= w_next_rem;
          r_low      <= {r_low[30:0], 1'b0};
          r_quotient <= {r_quotient[30:0], w_qbit};
          r_cnt      <= r_cnt - 5'd1;
          if (r_cnt == 5'd0) begin
            r_remainder <= w_next_rem[31:0];
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        S_OVF: begin
          r_quotient  <= 32'hFFFF_FFFF;
          r_remainder <= 32'h0;
          r_ovf       <= 1'b1;
`ifdef DIV64X32_DIV0_FLAG_EN
          r_div_zero  <= (r_div == 32'h0);
`endif
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.quotient  = r_quotient;
  assign bus.remainder = r_remainder;
  assign bus.ovf       = r_ovf;
`ifdef DIV64X32_DIV0_FLAG_EN
  assign bus.div_zero  = r_div_zero;
`endif

endmodule

// File: tb/tb_div64x32.sv
// Directed self-checking bench for div64x32: handshake latency, results, overflow, start
// masking and asynchronous reset abort, plus a short randomised sweep against 64-bit arithmetic.
module tb_div64x32;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  int   lat;

  div64x32_if dif ();

  div64x32 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch one operation; optionally pulse start with other operands at busy cycle inj.
  task automatic run_op(input logic [63:0] dd, input logic [31:0] dv, input int inj,
                        output int cycles);
    @(negedge clk);
    dif.start    = 1'b1;
    dif.dividend = dd;
    dif.divisor  = dv;
    @(negedge clk);
    dif.start    = 1'b0;
    dif.dividend = 64'h0000_0000_0000_004D;
    dif.divisor  = 32'd5;
    cycles = 0;
    while (dif.busy && cycles < 100) begin
      cycles++;
      dif.start = (cycles == inj);
      @(negedge clk);
    end
    dif.start = 1'b0;
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    reset        = 1'b0;
    dif.start    = 1'b0;
    dif.dividend = '0;
    dif.divisor  = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", dif.busy, 0);
    check("rst_quot", dif.quotient, 0);
    check("rst_rem", dif.remainder, 0);
    check("rst_ovf", dif.ovf, 0);
`ifdef DIV64X32_DIV0_FLAG_EN
    check("rst_dz", dif.div_zero, 0);
`endif
    reset = 1'b1;

    // 100 / 7
    run_op(64'd100, 32'd7, 0, lat);
    check("t1_lat", lat, 32);
    check("t1_quot", dif.quotient, 14);
    check("t1_rem", dif.remainder, 2);
    check("t1_ovf", dif.ovf, 0);

    // Largest legal quotient: (2^32-1)^2 / (2^32-1)
    run_op(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 0, lat);
    check("t2_lat", lat, 32);
    check("t2_quot", dif.quotient, 32'hFFFF_FFFF);
    check("t2_rem", dif.remainder, 0);

    // Divide by zero
    run_op(64'd1234, 32'd0, 0, lat);
    check("t3_lat", lat, 1);
    check("t3_ovf", dif.ovf, 1);
    check("t3_quot", dif.quotient, 32'hFFFF_FFFF);
    check("t3_rem", dif.remainder, 0);
`ifdef DIV64X32_DIV0_FLAG_EN
    check("t3_dz", dif.div_zero, 1);
`endif
    repeat (3) @(negedge clk);
    check("t3_hold_ovf", dif.ovf, 1);
    check("t3_hold_quot", dif.quotient, 32'hFFFF_FFFF);
    check("t3_hold_busy", dif.busy, 0);

    // Quotient overflow with non-zero divisor
    run_op({32'h5, 32'h0}, 32'd5, 0, lat);
    check("t4_lat", lat, 1);
    check("t4_ovf", dif.ovf, 1);
    check("t4_quot", dif.quotient, 32'hFFFF_FFFF);
`ifdef DIV64X32_DIV0_FLAG_EN
    check("t4_dz", dif.div_zero, 0);
`endif

    // Zero dividend clears ovf
    run_op(64'd0, 32'd1, 0, lat);
    check("t4b_lat", lat, 32);
    check("t4b_quot", dif.quotient, 0);
    check("t4b_rem", dif.remainder, 0);
    check("t4b_ovf", dif.ovf, 0);

    // Start pulsed at busy cycle 5 must be ignored: 1000 / 3 = 333 r 1
    run_op(64'd1000, 32'd3, 5, lat);
    check("t5_lat", lat, 32);
    check("t5_quot", dif.quotient, 333);
    check("t5_rem", dif.remainder, 1);

    // Start in the last busy cycle is ignored: 2^32 / 3 = 0x55555555 r 1
    run_op(64'h1_0000_0000, 32'd3, 32, lat);
    check("t5b_lat", lat, 32);
    @(negedge clk);
    check("t5b_busy", dif.busy, 0);
    check("t5b_quot", dif.quotient, 32'h5555_5555);
    check("t5b_rem", dif.remainder, 1);

    // Asynchronous reset at busy cycle 10
    @(negedge clk);
    dif.start    = 1'b1;
    dif.dividend = 64'd100;
    dif.divisor  = 32'd7;
    @(negedge clk);
    dif.start = 1'b0;
    repeat (9) @(negedge clk);
    check("t6_busy_pre", dif.busy, 1);
    #2 reset = 1'b0;
    #1;
    check("t6_busy", dif.busy, 0);
    check("t6_quot", dif.quotient, 0);
    check("t6_rem", dif.remainder, 0);
    check("t6_ovf", dif.ovf, 0);
    @(negedge clk);
    reset = 1'b1;
    run_op(64'd12345678, 32'd1000, 0, lat);
    check("t6_new_lat", lat, 32);
    check("t6_new_quot", dif.quotient, 12345);
    check("t6_new_rem", dif.remainder, 678);

    // Randomised legal operands against native 64-bit arithmetic
    for (int i = 0; i < 16; i++) begin
      logic [31:0] dv;
      logic [31:0] hi;
      logic [63:0] dd;
      logic [63:0] q_exp;
      logic [63:0] r_exp;
      dv = $urandom;
      if (dv == 32'h0) dv = 32'd1;
      hi = $urandom % dv;
      dd = {hi, 32'($urandom)};
      q_exp = dd / {32'h0, dv};
      r_exp = dd % {32'h0, dv};
      run_op(dd, dv, 0, lat);
      check("rnd_lat", lat, 32);
      check("rnd_quot", dif.quotient, q_exp);
      check("rnd_rem", dif.remainder, r_exp);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
